fifo_burst_reader: RTL and testbench

Read-side consumer for the dual-clock receive FIFO. Runs entirely in the FIFO's read clock domain. Waits until a full burst of samples is buffered, then drains exactly one burst, accounting for the FIFO's one-cycle registered read latency (non-showahead). Emits it as a framed packet (marker word, sequence word, BURST samples) on a valid/ready stream toward the host interface.

---
 rtl/fifo_burst_reader.sv | 214 +++++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side consumer for the dual-clock receive FIFO.
// Waits until one burst of samples is buffered, then drains exactly one burst
// and emits it as a framed packet (marker, sequence number, BURST samples)
// on a valid/ready stream. The FIFO is non-showahead: fifo_q is valid the
// cycle after fifo_rdreq, so returning words land in a 2-entry skid buffer.
// Stream outputs are decoded only from registered state, never from inputs.

module fifo_burst_reader #(
    parameter int               WIDTH  = 16,
    parameter int               WIDTHU = 9,
    parameter int               BURST  = 256,
    parameter logic [WIDTH-1:0] MARKER = 16'hA5A5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  fifo_q,
    input  logic              fifo_rdempty,
    input  logic [WIDTHU-1:0] fifo_rdusedw,
    output logic              fifo_rdreq,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy
);

    // Counters must hold the value 2^WIDTHU, hence one extra bit.
    localparam int            CW         = WIDTHU + 1;
    localparam logic [CW-1:0] BURST_C    = CW'(BURST);
    localparam logic [CW-1:0] FULL_LEVEL = {1'b1, {WIDTHU{1'b0}}};
    localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C      = {{WIDTHU{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR0 = 2'd1,
        ST_HDR1 = 2'd2,
        ST_BODY = 2'd3
    } state_t;

    // A completely full FIFO wraps its used-words count to zero; the empty
    // flag tells that case apart from a truly empty FIFO.
    function automatic logic [CW-1:0] effective_level(input logic [WIDTHU-1:0] usedw,
                                                      input logic              empty);
        logic [CW-1:0] lvl;
        if ((usedw == {WIDTHU{1'b0}}) && !empty) begin
            lvl = FULL_LEVEL;
        end else begin
            lvl = {1'b0, usedw};
        end
        return lvl;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  seq_r;
    logic [CW-1:0]     reads_left_r;
    logic [CW-1:0]     samples_left_r;
    logic              inflight_r;
    logic [WIDTH-1:0]  skid_mem_r [0:1];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic [1:0]        count_s;
    logic [1:0]        occ_s;
    logic [CW-1:0]     level_s;
    logic              start_s;
    logic              handshake_s;
    logic              pop_s;
    logic              push_s;
    logic              rdreq_s;

    assign level_s     = effective_level(fifo_rdusedw, fifo_rdempty);
    assign start_s     = (state_r == ST_IDLE) && enable && (level_s >= BURST_C);
    assign handshake_s = out_valid && out_ready;
    assign pop_s       = (state_r == ST_BODY) && handshake_s;
    assign push_s      = inflight_r;
    // Words held plus word returning, after this cycle's pop; never exceeds 2.
    assign occ_s       = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    assign fifo_rdreq  = rdreq_s;

    // Packet framing outputs decoded from the state and skid buffer registers.
    always_comb begin
        out_valid = 1'b0;
        out_data  = {WIDTH{1'b0}};
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_HDR0: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = MARKER;
                out_sop   = 1'b1;
            end
            ST_HDR1: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = seq_r;
            end
            ST_BODY: begin
                busy      = 1'b1;
                out_valid = (count_r != 2'd0);
                out_data  = skid_mem_r[rd_ptr_r];
                out_eop   = (count_r != 2'd0) && (samples_left_r == ONE_C);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Next-state logic for the packet sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_HDR0;
                else         state_s = ST_IDLE;
            end
            ST_HDR0: begin
                if (handshake_s) state_s = ST_HDR1;
                else             state_s = ST_HDR0;
            end
            ST_HDR1: begin
                if (handshake_s) state_s = ST_BODY;
                else             state_s = ST_HDR1;
            end
            ST_BODY: begin
                if (pop_s && (samples_left_r == ONE_C)) state_s = ST_IDLE;
                else                                     state_s = ST_BODY;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Read issue: keep the skid buffer topped up without ever overfilling it.
    always_comb begin
        rdreq_s = 1'b0;
        if (!reset && (state_r != ST_IDLE) && (reads_left_r != ZERO_C) &&
            !fifo_rdempty && (occ_s < 2'd2)) begin
            rdreq_s = 1'b1;
        end else begin
            rdreq_s = 1'b0;
        end
    end

    // Skid buffer occupancy update from this cycle's push and pop.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 2'd1;
            2'b01:   count_s = count_r - 2'd1;
            default: count_s = count_r;
        endcase
    end

    // State register and per-packet sequence number.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            seq_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == ST_HDR1) && handshake_s) begin
                seq_r <= seq_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Per-packet budgets: reads still to issue and samples still to emit.
    always_ff @(posedge clock) begin
        if (reset) begin
            reads_left_r   <= ZERO_C;
            samples_left_r <= ZERO_C;
        end else if (start_s) begin
            reads_left_r   <= BURST_C;
            samples_left_r <= BURST_C;
        end else begin
            if (rdreq_s) reads_left_r <= reads_left_r - ONE_C;
            if (pop_s)   samples_left_r <= samples_left_r - ONE_C;
        end
    end

    // Capture the word returning from the FIFO one cycle after each read.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_r    <= 1'b0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
            skid_mem_r[0] <= {WIDTH{1'b0}};
            skid_mem_r[1] <= {WIDTH{1'b0}};
        end else begin
            inflight_r <= rdreq_s;
            count_r    <= count_s;
            if (push_s) begin
                skid_mem_r[wr_ptr_r] <= fifo_q;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader. A queue models the non-showahead FIFO;
// the reference model tracks packets as "marker, sequence, next BURST words
// in FIFO order" and predicts starts from the buffered level.

module tb_fifo_burst_reader;

    localparam int         BURST  = 256;
    localparam int         DEPTH  = 512;
    localparam logic [15:0] MARKER = 16'hA5A5;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] fifo_q;
    logic        fifo_rdempty;
    logic [8:0]  fifo_rdusedw;
    logic        fifo_rdreq;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        busy;

    fifo_burst_reader #(
        .WIDTH (16),
        .WIDTHU(9),
        .BURST (BURST),
        .MARKER(MARKER)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fifo_q      (fifo_q),
        .fifo_rdempty(fifo_rdempty),
        .fifo_rdusedw(fifo_rdusedw),
        .fifo_rdreq  (fifo_rdreq),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    logic [15:0] fifo_m[$];
    logic [15:0] exp_s[$];
    logic [15:0] seq_seen[$];
    bit          pkt_active = 1'b0;
    int          idx = 0;
    logic [15:0] seq_m = 16'd0;
    int          rd_pkt = 0;
    int          pkt_cycles = 0;
    int          done_pkts = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    bit          rand_ready = 1'b0;
    bit          auto_feed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_flags();
        int sz;
        sz = fifo_m.size();
        fifo_rdempty = (sz == 0);
        fifo_rdusedw = sz[8:0];
    endtask

    task automatic push_word(input logic [15:0] w);
        if (fifo_m.size() < DEPTH) begin
            fifo_m.push_back(w);
            exp_s.push_back(w);
        end
    endtask

    function automatic logic [15:0] exp_word();
        if (idx == 0)         return MARKER;
        else if (idx == 1)    return seq_m;
        else if (exp_s.size() > 0) return exp_s[0];
        else                  return 16'hxxxx;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic tick();
        bit          hs;
        bit          rd;
        bit          start_now;
        bit          stall;
        logic [15:0] pdata;
        int          done_samples;
        @(negedge clock);
        if (reset) begin
            chk("rdreq_in_reset", 32'(fifo_rdreq), 32'(0));
        end else begin
            chk("busy", 32'(busy), 32'(pkt_active));
            chk("valid", 32'(out_valid), 32'(pkt_active));
            if (!pkt_active) begin
                chk("idle_data", 32'(out_data), 32'(0));
                chk("idle_flags", 32'({out_sop, out_eop}), 32'(0));
            end
            if (prev_stall) chk("stall_hold", 32'(out_data), 32'(prev_data));
            if (pkt_active && out_valid) begin
                chk("sop", 32'(out_sop), 32'(idx == 0));
                chk("eop", 32'(out_eop), 32'(idx == BURST + 1));
                chk("word", 32'(out_data), 32'(exp_word()));
            end
            if (pkt_active && idx == 0) chk("first_rdreq", 32'(fifo_rdreq), 32'(1));
            if (fifo_rdreq === 1'b1)
                chk("rdreq_legal", 32'(pkt_active && fifo_m.size() > 0 && rd_pkt < BURST), 32'(1));
            if (pkt_active) pkt_cycles++;
        end
        hs        = !reset && (out_valid === 1'b1) && out_ready;
        rd        = (fifo_rdreq === 1'b1);
        start_now = !reset && !pkt_active && enable && (fifo_m.size() >= BURST);
        stall     = !reset && (out_valid === 1'b1) && !out_ready;
        pdata     = out_data;
        @(posedge clock);
        #1;
        if (rd && fifo_m.size() > 0) begin
            fifo_q = fifo_m.pop_front();
            rd_pkt++;
        end
        if (reset) begin
            pkt_active = 1'b0;
            seq_m      = 16'd0;
            idx        = 0;
            exp_s      = fifo_m;
            stall      = 1'b0;
        end else if (hs && pkt_active) begin
            if (idx == 1) begin
                seq_seen.push_back(pdata);
                seq_m = seq_m + 16'd1;
            end
            if (idx >= 2) void'(exp_s.pop_front());
            if (idx == BURST + 1) begin
                pkt_active = 1'b0;
                chk("reads_per_pkt", 32'(rd_pkt), 32'(BURST));
                done_pkts++;
            end
            idx++;
        end else if (start_now) begin
            pkt_active = 1'b1;
            idx        = 0;
            rd_pkt     = 0;
            pkt_cycles = 0;
        end
        if (pkt_active) begin
            done_samples = (idx > 2) ? idx - 2 : 0;
            chk("skid_occupancy", 32'(rd_pkt - done_samples <= 2), 32'(1));
        end
        prev_stall = stall;
        prev_data  = pdata;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        if (auto_feed) push_word(16'($urandom));
        set_flags();
    endtask

    task automatic run_pkts(input int n, input int budget);
        int target;
        int cyc;
        target = done_pkts + n;
        cyc    = 0;
        while (done_pkts < target && cyc < budget) begin
            tick();
            cyc++;
        end
        if (done_pkts < target) chk("timeout_pkts", 32'(done_pkts), 32'(target));
    endtask

    task automatic run_to_idx(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (!(pkt_active && idx >= n) && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!(pkt_active && idx >= n)) chk("timeout_idx", 32'(idx), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int cyc;
        cyc = 0;
        while (pkt_active && cyc < budget) begin
            tick();
            cyc++;
        end
        if (pkt_active) chk("timeout_idle", 32'(pkt_active), 32'(0));
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b1;
        fifo_q    = 16'd0;
        set_flags();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", 32'(busy), 32'(0));

        // Burst of 0..255 with out_ready held high.
        for (int i = 0; i < BURST; i++) push_word(16'(i));
        set_flags();
        enable = 1'b1;
        run_pkts(1, 400);
        chk("contiguous_valid", 32'(pkt_cycles), 32'(BURST + 2));
        tick();

        // 255 words: no start; one more word starts the packet.
        for (int i = 0; i < BURST - 1; i++) push_word(16'(16'h1000 + i));
        set_flags();
        for (int i = 0; i < 8; i++) tick();
        chk("below_burst_idle", 32'(busy), 32'(0));
        push_word(16'h1FFF);
        set_flags();
        tick();
        chk("start_after_fill", 32'(busy), 32'(1));
        chk("start_sop", 32'(out_sop), 32'(1));
        run_pkts(1, 400);

        // Random backpressure over three packets, sequence restarts at 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(16'($urandom));
        set_flags();
        rand_ready = 1'b1;
        auto_feed  = 1'b1;
        base = seq_seen.size();
        run_pkts(3, 3000);
        if (seq_seen.size() >= base + 3) begin
            chk("seq_0", 32'(seq_seen[base]), 32'(0));
            chk("seq_1", 32'(seq_seen[base + 1]), 32'(1));
            chk("seq_2", 32'(seq_seen[base + 2]), 32'(2));
        end else begin
            chk("seq_count", 32'(seq_seen.size()), 32'(base + 3));
        end
        enable     = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_idle(1000);
        auto_feed = 1'b0;
        tick();

        // Completely full FIFO (usedw wraps to 0) still starts a packet.
        while (fifo_m.size() < DEPTH) push_word(16'($urandom));
        set_flags();
        enable = 1'b1;
        tick();
        chk("full_start", 32'(busy), 32'(1));

        // Drop enable at sample 100: packet completes, then stays idle.
        run_to_idx(102, 400);
        enable = 1'b0;
        wait_idle(400);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("stay_idle", 32'(busy), 32'(0));
        end
        chk("fifo_still_has_burst", 32'(fifo_m.size() >= BURST), 32'(1));

        // Reset at sample 50, refill, next packet carries sequence 0.
        enable = 1'b1;
        run_to_idx(52, 400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) push_word(16'($urandom));
        set_flags();
        base = seq_seen.size();
        run_pkts(1, 600);
        if (seq_seen.size() > base) chk("seq_after_reset", 32'(seq_seen[base]), 32'(0));
        else chk("seq_after_reset_seen", 32'(seq_seen.size()), 32'(base + 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
